id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage of the 16-bit processor.
- Holds the 8×16 register file, which takes one synchronous write and serves two combinational reads.
- Sign- or zero-extends the 8-bit immediate/jump field and passes PC+4 through to the next stage.
- Sits between the IF and EX stages; the write port is driven from writeback.

Parameters:
- DATA_W, 16, width of registers, data, PC and extended immediate.
- REG_ADDR_W, 3, register index width (2**REG_ADDR_W = 8 registers).
- IMM_W, 8, width of addressjump field.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- rs  in  3  read address, port 1.
- rt  in  3  read address, port 2.
- rd  in  3  write address.
- funct  in  2  function field; selects the extension mode.
- addressjump  in  8  immediate/jump field to extend.
- PC4  in  16  PC+4 from fetch.
- writeDat  in  16  writeback data.
- RegWrite  in  1  write enable.
- readData1  out  16  contents of register rs.
- readData2  out  16  contents of register rt.
- extendedSignal  out  16  extended addressjump.
- PC4_outpuID  out  16  PC+4 forwarded.

Behaviour:
- Reset: on a rising edge with reset=1, all 8 registers clear to 0. Reset has priority over a simultaneous write.
  - Outputs derived from registers (readData1/2) therefore read 0 after reset.
  - extendedSignal and PC4_outpuID are purely combinational and unaffected by reset.
- Write: on a rising edge with reset=0 and RegWrite=1, reg[rd] <= writeDat. The new value is visible on the read ports after that edge (1-cycle write latency).
  - With RegWrite=0, no register changes.
- Register 0 is hardwired to zero:
  - Writes to rd=0 are ignored.
  - Reading rs=0 or rt=0 returns 16'h0000.
- Reads are combinational: readData1 = reg[rs], readData2 = reg[rt].
  - rs == rt is legal; both ports return the same value.
  - Reading the register being written in the same cycle returns the OLD value (unless the bypass feature is enabled).
- Extension:
  - funct == 2'b11: zero-extend, {8'h00, addressjump}.
  - Any other funct: sign-extend, {{8{addressjump[7]}}, addressjump}.
- PC4_outpuID = PC4, combinational, no register stage.
- X/undefined inputs are not defined behaviour; with RegWrite=0, an X on rd/writeDat must not corrupt state.

Optional Feature:
- Macro ID_BYPASS_EN.
- Defined: write-through forwarding is enabled.
  - If RegWrite=1, reset=0, rd!=0 and rd==rs, then readData1 = writeDat combinationally in the same cycle.
  - The same rule applies to rt/readData2.
- Undefined: reads always return the stored register value; a same-cycle write is seen only after the edge.

Decomposition:
- Shared package (proc_pkg) holds:
  - constants DATA_W, REG_ADDR_W, IMM_W, NUM_REGS;
  - FUNCT_ZEXT = 2'b11;
  - typedefs data_t (logic [15:0]) and reg_idx_t (logic [2:0]).
- One natural sub-module, reg_file, implements:
  - the 8×16 storage array, reset, r0 hardwiring, two read ports and the optional bypass.
- Extension and PC4 pass-through stay in id_stage.

Test Plan:
- Reset then read: reset=1 for one edge, then rs=1, rt=3 -> readData1=readData2=16'h0000.
- Write then read:
  - RegWrite=1, rd=4, writeDat=16'h0008 at edge.
  - Next cycle, RegWrite=1, rs=rt=4, rd=6, writeDat=16'h000F -> readData1=readData2=16'h0008 (no bypass). 16'h000F is read from reg 6 after the following edge.
- Sign extension: funct=2'b10, addressjump=8'b10011111 -> extendedSignal=16'hFF9F; funct=2'b11 with the same field -> 16'h009F.
- r0 protection: write rd=0, writeDat=16'hBEEF, RegWrite=1 -> reading rs=0 returns 16'h0000. Write with RegWrite=0 to rd=5 -> reg 5 unchanged.
- Pass-through and reset priority:
  - PC4=16'h1234 -> PC4_outpuID=16'h1234 in the same cycle.
  - reset=1 with RegWrite=1, rd=2, writeDat=16'hAAAA -> reg 2 reads 0 afterwards.
- Bypass (ID_BYPASS_EN): RegWrite=1, rd=rs=3, writeDat=16'h5A5A -> readData1=16'h5A5A before the edge. Without the macro -> the old value is returned.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants and types for the 16-bit processor datapath.
package proc_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int IMM_W      = 8;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  localparam logic [1:0] FUNCT_ZEXT = 2'b11;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file.sv
// 8x16 register file: one synchronous write, two combinational reads, r0 = 0.
// Define ID_BYPASS_EN for same-cycle write-through forwarding.
module reg_file
  import proc_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rt,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic [DATA_W-1:0]     i_wd,
  input  logic                  i_we,
  output logic [DATA_W-1:0]     o_rd1,
  output logic [DATA_W-1:0]     o_rd2
);

  data_t r_regs [NUM_REGS];
  logic  w_wr;

  // r0 is never written, so it stays at its reset value
  assign w_wr = i_we && (i_rd != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr) begin
      r_regs[i_rd] <= i_wd;
    end
  end

`ifdef ID_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;

  assign w_fwd1 = w_wr && !i_rst && (i_rd == i_rs);
  assign w_fwd2 = w_wr && !i_rst && (i_rd == i_rt);

  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    if (w_fwd1) begin
      o_rd1 = i_wd;
    end else if (i_rs != '0) begin
      o_rd1 = r_regs[i_rs];
    end
    if (w_fwd2) begin
      o_rd2 = i_wd;
    end else if (i_rt != '0) begin
      o_rd2 = r_regs[i_rt];
    end
  end
`else
  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    if (i_rs != '0) begin
      o_rd1 = r_regs[i_rs];
    end
    if (i_rt != '0) begin
      o_rd2 = r_regs[i_rt];
    end
  end
`endif

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: register file, immediate extension, PC+4 pass.
// Define ID_BYPASS_EN to forward same-cycle writeback data to the reads.
module id_stage
  import proc_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [1:0]            funct,
  input  logic [IMM_W-1:0]      addressjump,
  input  logic [DATA_W-1:0]     PC4,
  input  logic [DATA_W-1:0]     writeDat,
  input  logic                  RegWrite,
  output logic [DATA_W-1:0]     readData1,
  output logic [DATA_W-1:0]     readData2,
  output logic [DATA_W-1:0]     extendedSignal,
  output logic [DATA_W-1:0]     PC4_outpuID
);

  logic w_zext;

  reg_file u_rf (
    .i_clk (clock),
    .i_rst (reset),
    .i_rs  (rs),
    .i_rt  (rt),
    .i_rd  (rd),
    .i_wd  (writeDat),
    .i_we  (RegWrite),
    .o_rd1 (readData1),
    .o_rd2 (readData2)
  );

  assign w_zext = (funct == FUNCT_ZEXT);

  assign extendedSignal = w_zext
    ? {{(DATA_W-IMM_W){1'b0}}, addressjump}
    : {{(DATA_W-IMM_W){addressjump[IMM_W-1]}}, addressjump};

  assign PC4_outpuID = PC4;

endmodule

// File: tb/tb_id_stage.sv
// Table-driven bench for id_stage with a queue of expected read results.
module tb_id_stage;

  logic        clock;
  logic        reset;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic [2:0]  rd;
  logic [1:0]  funct;
  logic [7:0]  addressjump;
  logic [15:0] PC4;
  logic [15:0] writeDat;
  logic        RegWrite;
  logic [15:0] readData1;
  logic [15:0] readData2;
  logic [15:0] extendedSignal;
  logic [15:0] PC4_outpuID;

  id_stage dut (
    .clock          (clock),
    .reset          (reset),
    .rs             (rs),
    .rt             (rt),
    .rd             (rd),
    .funct          (funct),
    .addressjump    (addressjump),
    .PC4            (PC4),
    .writeDat       (writeDat),
    .RegWrite       (RegWrite),
    .readData1      (readData1),
    .readData2      (readData2),
    .extendedSignal (extendedSignal),
    .PC4_outpuID    (PC4_outpuID)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        we;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [15:0] wd;
    logic [1:0]  funct;
    logic [7:0]  aj;
    logic [15:0] pc4;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] eext;
    logic [15:0] epc;
  } vec_t;

  typedef struct {
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] eext;
    logic [15:0] epc;
  } exp_t;

  vec_t vecs [12];
  exp_t sb [$];
  int   n_pass;
  int   n_total;

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    @(negedge clock);
    reset       = v.rst;
    RegWrite    = v.we;
    rs          = v.rs;
    rt          = v.rt;
    rd          = v.rd;
    writeDat    = v.wd;
    funct       = v.funct;
    addressjump = v.aj;
    PC4         = v.pc4;
    e.e1   = v.e1;
    e.e2   = v.e2;
    e.eext = v.eext;
    e.epc  = v.epc;
    sb.push_back(e);
  endtask

  task automatic check_out(input int idx);
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard[%0d]: got empty queue expected entry", idx);
    end else begin
      e = sb.pop_front();
      chk("readData1", idx, readData1, e.e1);
      chk("readData2", idx, readData2, e.e2);
      chk("extendedSignal", idx, extendedSignal, e.eext);
      chk("PC4_outpuID", idx, PC4_outpuID, e.epc);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    drive(v);
    check_out(idx);
    @(posedge clock);
  endtask

  vec_t hv;

  initial begin
    n_pass  = 0;
    n_total = 0;
    //           rst we  rs    rt    rd    wd        fn     aj      pc4       e1        e2        ext       epc
    vecs[0]  = '{0, 0, 3'd1, 3'd3, 3'd0, 16'h0000, 2'b00, 8'h00, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 16'h0004};
    vecs[1]  = '{0, 1, 3'd1, 3'd3, 3'd4, 16'h0008, 2'b10, 8'h9F, 16'h1234, 16'h0000, 16'h0000, 16'hFF9F, 16'h1234};
    vecs[2]  = '{0, 1, 3'd4, 3'd4, 3'd6, 16'h000F, 2'b11, 8'h9F, 16'h0008, 16'h0008, 16'h0008, 16'h009F, 16'h0008};
    vecs[3]  = '{0, 0, 3'd6, 3'd4, 3'd0, 16'h0000, 2'b01, 8'h7F, 16'hFFFC, 16'h000F, 16'h0008, 16'h007F, 16'hFFFC};
    vecs[4]  = '{0, 1, 3'd0, 3'd6, 3'd0, 16'hBEEF, 2'b00, 8'h80, 16'h0100, 16'h0000, 16'h000F, 16'hFF80, 16'h0100};
    vecs[5]  = '{0, 1, 3'd0, 3'd0, 3'd5, 16'h1111, 2'b11, 8'h80, 16'h0104, 16'h0000, 16'h0000, 16'h0080, 16'h0104};
    vecs[6]  = '{0, 0, 3'd5, 3'd0, 3'd5, 16'h2222, 2'b10, 8'h01, 16'h0108, 16'h1111, 16'h0000, 16'h0001, 16'h0108};
    vecs[7]  = '{0, 0, 3'd5, 3'd5, 3'd5, 16'h3333, 2'b11, 8'hFF, 16'h010C, 16'h1111, 16'h1111, 16'h00FF, 16'h010C};
    vecs[8]  = '{1, 1, 3'd4, 3'd6, 3'd2, 16'hAAAA, 2'b00, 8'hFF, 16'hA5A5, 16'h0008, 16'h000F, 16'hFFFF, 16'hA5A5};
    vecs[9]  = '{0, 0, 3'd2, 3'd4, 3'd0, 16'h0000, 2'b10, 8'h00, 16'h5A5A, 16'h0000, 16'h0000, 16'h0000, 16'h5A5A};
    vecs[10] = '{0, 1, 3'd5, 3'd1, 3'd7, 16'hFFFF, 2'b01, 8'h55, 16'h0200, 16'h0000, 16'h0000, 16'h0055, 16'h0200};
    vecs[11] = '{0, 0, 3'd7, 3'd2, 3'd0, 16'h0000, 2'b11, 8'hAA, 16'h0204, 16'hFFFF, 16'h0000, 16'h00AA, 16'h0204};

    reset = 1'b1;
    RegWrite = 1'b0;
    rs = '0; rt = '0; rd = '0;
    funct = '0; addressjump = '0;
    PC4 = '0; writeDat = '0;
    @(posedge clock);

    for (int i = 0; i < 12; i++) begin
      run(vecs[i], i);
    end

    // same-cycle write/read of r3 (currently 0)
    hv = '{0, 1, 3'd3, 3'd3, 3'd3, 16'h5A5A, 2'b00, 8'h12, 16'h0300,
`ifdef ID_BYPASS_EN
           16'h5A5A, 16'h5A5A,
`else
           16'h0000, 16'h0000,
`endif
           16'h0012, 16'h0300};
    run(hv, 100);
    hv = '{0, 0, 3'd3, 3'd0, 3'd3, 16'h1234, 2'b11, 8'h12, 16'h0304,
           16'h5A5A, 16'h0000, 16'h0012, 16'h0304};
    run(hv, 101);

    // write during reset with X-free data, then idle write with X on rd/data
    hv = '{1, 1, 3'd3, 3'd7, 3'd3, 16'h7777, 2'b10, 8'h80, 16'h0308,
           16'h5A5A, 16'hFFFF, 16'hFF80, 16'h0308};
    run(hv, 102);
    @(negedge clock);
    reset = 1'b0;
    RegWrite = 1'b0;
    rd = 3'bxxx;
    writeDat = 16'hxxxx;
    rs = 3'd3;
    rt = 3'd7;
    @(posedge clock);
    #1;
    chk("x_idle_rs3", 103, readData1, 16'h0000);
    chk("x_idle_rt7", 103, readData2, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
